// File: rtl/sorted_vec_serializer.sv
// Captures one N-element vector and streams it out one element per beat.
// Each vector is checked for a non-decreasing order and failing vectors are counted.
module sorted_vec_serializer #(
  parameter int N     = 6,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [WIDTH-1:0] vec_data_i [N],
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [IDXW-1:0]  out_index_o,
  output logic             out_last_o,
  output logic             done_o,
  output logic             vec_err_o,
  output logic [7:0]       err_count_o
);

  // state | meaning
  // IDLE  | waiting for a vector; vec_ready high
  // SEND  | streaming vbuf[idx]; out_valid high
  // DONE  | one-cycle done pulse; vec_err valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vbuf_q [N];
  logic [WIDTH-1:0] vbuf_d [N];
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             err_acc_q, err_acc_d;
  logic             vec_err_q, vec_err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] cur_elem;
  logic             in_send;
  logic             beat;
  logic             descent;

  assign cur_elem = vbuf_q[idx_q];
  assign in_send  = (state_q == SEND);
  assign beat     = in_send && out_ready_i;
  // The first element has no predecessor, so it can never be a descent.
  assign descent  = (idx_q != '0) && (cur_elem < prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      prev_q      <= '0;
      err_acc_q   <= 1'b0;
      vec_err_q   <= 1'b0;
      err_count_q <= '0;
      for (int i = 0; i < N; i++) begin
        vbuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prev_q      <= prev_d;
      err_acc_q   <= err_acc_d;
      vec_err_q   <= vec_err_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < N; i++) begin
        vbuf_q[i] <= vbuf_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    prev_d      = prev_q;
    err_acc_d   = err_acc_q;
    vec_err_d   = vec_err_q;
    err_count_d = err_count_q;
    for (int i = 0; i < N; i++) begin
      vbuf_d[i] = vbuf_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (vec_valid_i) begin
          for (int i = 0; i < N; i++) begin
            vbuf_d[i] = vec_data_i[i];
          end
          idx_d     = '0;
          prev_d    = '0;
          err_acc_d = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          prev_d = cur_elem;
          if (descent) begin
            err_acc_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            // Latch the verdict here so it is already valid during DONE.
            vec_err_d = err_acc_q | descent;
            state_d   = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (vec_err_q && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign vec_ready_o = (state_q == IDLE);
  assign out_valid_o = in_send;
  assign out_data_o  = in_send ? cur_elem : '0;
  assign out_index_o = in_send ? idx_q : '0;
  assign out_last_o  = in_send && (idx_q == LAST_IDX);
  assign done_o      = (state_q == DONE);
  assign vec_err_o   = vec_err_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_sorted_vec_serializer.sv
// Directed bench for sorted_vec_serializer: streaming, backpressure, order checking,
// handshake isolation, mid-stream reset and error-count saturation.
module tb_sorted_vec_serializer;

  localparam int N = 6;
  localparam int W = 8;

  typedef logic [W-1:0] vec_t [N];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vec_valid = 1'b0;
  logic         vec_ready;
  vec_t         vec_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   out_index;
  logic         out_last;
  logic         done;
  logic         vec_err;
  logic [7:0]   err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sorted_vec_serializer #(.N(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vec_valid_i (vec_valid),
    .vec_ready_o (vec_ready),
    .vec_data_i  (vec_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_index_o (out_index),
    .out_last_o  (out_last),
    .done_o      (done),
    .vec_err_o   (vec_err),
    .err_count_o (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle just after a clock edge. Captures v, then streams it
  // while vec_data carries 'other' (vec_valid held high when 'hold' is set).
  task automatic send_vec(input vec_t v, input vec_t other, input bit bp, input bit hold,
                          input bit exp_err, input logic [7:0] exp_cnt);
    int   k;
    int   cyc;
    logic rdy;
    chk("idle_ready", {31'd0, vec_ready}, 32'd1);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    vec_data  = v;
    vec_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    vec_data  = other;
    vec_valid = hold;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 60) begin
      rdy       = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_data",  {24'd0, out_data}, {24'd0, v[k]});
      chk("beat_index", {29'd0, out_index}, k);
      chk("beat_last",  {31'd0, out_last}, (k == N - 1) ? 32'd1 : 32'd0);
      chk("beat_vready", {31'd0, vec_ready}, 32'd0);
      chk("beat_done",  {31'd0, done}, 32'd0);
      tick();
      if (rdy) k++;
      cyc++;
    end
    if (k < N) chk("stream_timeout", k, N);
    out_ready = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_err",   {31'd0, vec_err}, {31'd0, exp_err});
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    chk("done_vready", {31'd0, vec_ready}, 32'd0);
    tick();
    vec_valid = 1'b0;
    chk("post_done",  {31'd0, done}, 32'd0);
    chk("post_err",   {31'd0, vec_err}, {31'd0, exp_err});
    chk("post_cnt",   {24'd0, err_count}, {24'd0, exp_cnt});
    chk("post_vready", {31'd0, vec_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_vready", {31'd0, vec_ready}, 32'd1);
    chk("rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_data",   {24'd0, out_data}, 32'd0);
    chk("rst_index",  {29'd0, out_index}, 32'd0);
    chk("rst_last",   {31'd0, out_last}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_err",    {31'd0, vec_err}, 32'd0);
    chk("rst_cnt",    {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    vec_t inc, desc1, flat, lastdesc, rev, junk;
    logic [7:0] cnt;
    inc      = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    desc1    = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9};
    flat     = '{8'd0, 8'd0, 8'd7, 8'd7, 8'd255, 8'd255};
    lastdesc = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    rev      = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};
    junk     = '{8'd200, 8'd17, 8'd99, 8'd3, 8'd250, 8'd42};
    vec_data = '{default: 8'd0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    send_vec(inc, junk, 1'b0, 1'b0, 1'b0, 8'd0);
    send_vec(inc, junk, 1'b1, 1'b0, 1'b0, 8'd0);
    send_vec(desc1, junk, 1'b0, 1'b0, 1'b1, 8'd1);
    send_vec(flat, junk, 1'b1, 1'b0, 1'b0, 8'd1);
    send_vec(lastdesc, junk, 1'b0, 1'b0, 1'b1, 8'd2);
    // vec_valid stays high carrying desc1 for the whole inc stream
    send_vec(inc, desc1, 1'b1, 1'b1, 1'b0, 8'd2);
    send_vec(desc1, junk, 1'b0, 1'b0, 1'b1, 8'd3);

    vec_data  = rev;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    vec_data  = junk;
    out_ready = 1'b1;
    tick();
    tick();
    chk("mid_index", {29'd0, out_index}, 32'd2);
    chk("mid_data",  {24'd0, out_data}, 32'd7);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_hold_done", {31'd0, done}, 32'd0);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_reset_vals();
    send_vec(inc, junk, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 260; i++) begin
      cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      send_vec(rev, junk, 1'b0, 1'b0, 1'b1, cnt);
    end
    chk("sat_final", {24'd0, err_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sorted_vec_serializer.md
# sorted_vec_serializer

Sequential consumer for the parallel sorter output. It captures one N-element vector through a valid/ready handshake and streams the elements out one per beat, in index order, on a second valid/ready handshake. As the elements stream, it checks that the sequence is non-decreasing. At the end of each vector it reports a per-vector order-error flag and keeps a saturating count of vectors that failed. It sits directly downstream of the combinational sorter and gives the rest of the design a narrow serial interface plus a built-in ordering monitor.

## Interface
- N, 6, elements per vector; legal range 2..64
- WIDTH, 8, bits per element (unsigned)
- IDXW, $clog2(N), derived width of out_index; not overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock domain only
- vec_valid  input  1  vec_data holds a vector to capture
- vec_ready  output  1  block can accept a vector
- vec_data  input  WIDTH x N (unpacked [N])  vector from the sorter; element 0 streams first
- out_valid  output  1  out_data/out_index/out_last are valid
- out_ready  input  1  downstream accepts the current beat
- out_data  output  WIDTH  current element
- out_index  output  IDXW  index of the current element, 0..N-1
- out_last  output  1  current beat is element N-1
- done  output  1  one-cycle pulse: vec_err is valid for the vector just finished
- vec_err  output  1  vector just finished contained a descent
- err_count  output  8  saturating count of vectors with vec_err=1

## Operation
- States: IDLE, SEND, DONE. Reset state is IDLE.
- **IDLE**
  - vec_ready=1, out_valid=0.
  - On vec_valid&&vec_ready: capture all N elements into an internal buffer, clear idx, prev and the accumulated error, then go to SEND.
- **SEND**
  - vec_ready=0, out_valid=1.
  - out_data=buf[idx], out_index=idx, out_last=(idx==N-1).
  - An accepted beat is out_valid&&out_ready. On each accepted beat:
    - if idx>0 and buf[idx] < prev (unsigned compare), set the accumulated error;
    - then prev<=buf[idx].
  - Accepted beat with idx<N-1: idx<=idx+1.
  - Accepted beat with idx==N-1: go to DONE.
  - While out_ready=0, all outputs hold stable and idx does not change.
- **DONE** (exactly one cycle)
  - done=1, vec_err=the accumulated error (including the final beat's check).
  - If vec_err=1 and err_count<255, err_count increments on this edge.
  - Next state is IDLE.
- Equal adjacent elements are legal and never flag an error.
- Once captured, the vector is held internally. vec_data may change freely after the capture edge without affecting the stream.
- vec_err holds its value until the next DONE. It reads 0 from reset until the first DONE.
- err_count never wraps: it stays at 255 once reached. It is cleared only by reset.

## Timing
- **Reset values:** vec_ready=1 (IDLE), out_valid=0, out_data=0, out_index=0, out_last=0, done=0, vec_err=0, err_count=0.
- **rst_n low mid-stream:** the vector is discarded and no done pulse is produced. After rst_n deasserts, the block returns to IDLE on the next clock edge.
- **Capture to first beat:** out_valid is high in the cycle after the capture edge (latency 1).
- **Last beat to done:** done is high in the cycle after the last accepted beat.
- **DONE to next capture:** vec_ready returns to 1 in the cycle after DONE.
- **Throughput:** minimum occupancy is N+2 cycles per vector (capture edge, N beats, DONE), with out_ready held at 1.
- vec_ready is 0 in SEND and DONE, so a vec_valid held high during a stream is ignored until IDLE.
- out_valid never drops once raised until its beat is accepted (standard valid/ready rule). out_data must not change while out_valid=1 and out_ready=0.
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready or vec_valid to any output.

## Test plan
- **Basic stream:** capture [1,2,3,4,5,6] with out_ready=1. Required: 6 beats on consecutive cycles, out_index 0..5, out_last only on value 6, done one cycle later with vec_err=0, err_count=0.
- **Backpressure:** same vector with out_ready toggling 1,0,0,1,… Required: each beat holds stable while out_ready=0; no element is duplicated or dropped; done follows the 6th accepted beat.
- **Descent detection:** capture [3,1,4,1,5,9]. Required: done with vec_err=1, err_count=1. Then capture [0,0,7,7,255,255]. Required: vec_err=0, err_count stays 1.
- **Handshake isolation:** hold vec_valid=1 with a new vector throughout a stream. Required: vec_ready=0 during SEND and DONE; the second vector is captured only on the first IDLE cycle; the stream contents are unaffected by vec_data changes.
- **Reset mid-stream:** assert rst_n=0 after beat 2 of [9,8,7,6,5,4]. Required: all outputs return immediately to reset values; no done pulse; err_count=0; a new vector streams normally after reset.
- **Saturation:** feed 260 descending vectors. Required: err_count reaches 255 and stays there; vec_err=1 on every done pulse.
